// File: rtl/rx_slip_controller_if.sv
// Header, slip and status signals between the RX gearbox, the lock FSM and
// the slip controller. The slave modport is the controller's view.
interface rx_slip_controller_if #(
  parameter int HDR_WIDTH      = 2,
  parameter int BLOCK_BITS     = 66,
  parameter int LOSS_CNT_WIDTH = 16
);
  localparam int OFF_W = $clog2(BLOCK_BITS);

  // i_hdr_valid is a one-cycle strobe with no backpressure: a header offered
  // on a clock edge is consumed on that edge; o_hdr_valid follows the same rule.
  logic [HDR_WIDTH-1:0]      i_hdr;
  logic                      i_hdr_valid;
  logic [HDR_WIDTH-1:0]      o_hdr;
  logic                      o_hdr_valid;
  logic                      i_slip_req;
  logic                      i_block_lock;
  logic                      o_gb_slip;
  logic [OFF_W-1:0]          o_slip_offset;
  logic                      o_sync_fail;
  logic                      i_clear_fail;
  logic [LOSS_CNT_WIDTH-1:0] o_lock_loss_cnt;
  logic [2:0]                o_state;

  modport slave (
    input  i_hdr, i_hdr_valid, i_slip_req, i_block_lock, i_clear_fail,
    output o_hdr, o_hdr_valid, o_gb_slip, o_slip_offset, o_sync_fail,
           o_lock_loss_cnt, o_state
  );

  modport master (
    output i_hdr, i_hdr_valid, i_slip_req, i_block_lock, i_clear_fail,
    input  o_hdr, o_hdr_valid, o_gb_slip, o_slip_offset, o_sync_fail,
           o_lock_loss_cnt, o_state
  );
endinterface

// File: rtl/rx_slip_controller.sv
// Bit-slip sequencer between the 10GBASE-R RX gearbox and the block lock FSM:
// header forwarding, slip pulses with settle holdoff, sweep and lock-loss tracking.
module rx_slip_controller #(
  parameter int HDR_WIDTH      = 2,
  parameter int BLOCK_BITS     = 66,
  parameter int SLIP_HOLDOFF   = 4,
  parameter int MAX_SWEEPS     = 2,
  parameter int LOSS_CNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  rx_slip_controller_if.slave   bus
);
  localparam int OFF_W   = $clog2(BLOCK_BITS);
  localparam int SWEEP_W = $clog2(MAX_SWEEPS + 1);
  localparam int HOLD_W  = $clog2(SLIP_HOLDOFF + 1);

  localparam logic [OFF_W-1:0]          OFF_LAST    = OFF_W'(BLOCK_BITS - 1);
  localparam logic [SWEEP_W-1:0]        SWEEP_LIMIT = SWEEP_W'(MAX_SWEEPS);
  localparam logic [HOLD_W-1:0]         HOLD_LAST   = HOLD_W'(SLIP_HOLDOFF - 1);
  localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_MAX    = '1;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_SLIP    = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [HDR_WIDTH-1:0]      hdr;
  logic                      hdr_valid, hdr_valid_nxt;
  logic                      gb_slip, sync_fail;
  logic [OFF_W-1:0]          offset;
  logic [SWEEP_W-1:0]        sweep;
  logic [HOLD_W-1:0]         hold_cnt;
  logic [LOSS_CNT_WIDTH-1:0] loss_cnt;
  logic                      offset_wrap;
  logic [SWEEP_W-1:0]        sweep_inc;

  assign offset_wrap = (offset == OFF_LAST);
  assign sweep_inc   = sweep + SWEEP_W'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_HUNT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT: begin
        if (bus.i_slip_req)        state_nxt = ST_SLIP;
        else if (bus.i_block_lock) state_nxt = ST_LOCKED;
      end
      // The wrap decision uses the pre-increment offset, so the sweep that
      // just completed is the one counted against the limit.
      ST_SLIP: begin
        if (offset_wrap && (sweep_inc == SWEEP_LIMIT)) state_nxt = ST_FAIL;
        else                                            state_nxt = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (bus.i_hdr_valid && (hold_cnt == HOLD_LAST)) state_nxt = ST_HUNT;
      end
      ST_LOCKED: begin
        if (bus.i_slip_req)         state_nxt = ST_SLIP;
        else if (!bus.i_block_lock) state_nxt = ST_HUNT;
      end
      ST_FAIL: begin
        if (bus.i_clear_fail) state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // Header strobe is gated by the state the header arrived in, so the header
  // seen during the slip cycle is dropped along with the holdoff headers.
  always_comb begin
    hdr_valid_nxt = 1'b0;
    if ((state == ST_HUNT) || (state == ST_LOCKED)) hdr_valid_nxt = bus.i_hdr_valid;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hdr       <= '0;
      hdr_valid <= 1'b0;
      gb_slip   <= 1'b0;
      sync_fail <= 1'b0;
      offset    <= '0;
      sweep     <= '0;
      hold_cnt  <= '0;
      loss_cnt  <= '0;
    end else begin
      hdr       <= bus.i_hdr;
      hdr_valid <= hdr_valid_nxt;
      gb_slip   <= (state_nxt == ST_SLIP);
      sync_fail <= (state_nxt == ST_FAIL);
      case (state)
        ST_HUNT: begin
          if (state_nxt == ST_LOCKED) sweep <= '0;
        end
        ST_SLIP: begin
          hold_cnt <= '0;
          if (offset_wrap) begin
            offset <= '0;
            sweep  <= sweep_inc;
          end else begin
            offset <= offset + OFF_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (bus.i_hdr_valid) hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        ST_LOCKED: begin
          if (bus.i_slip_req) begin
            sweep <= '0;
            if (loss_cnt != LOSS_MAX) loss_cnt <= loss_cnt + LOSS_CNT_WIDTH'(1);
          end
        end
        ST_FAIL: begin
          if (bus.i_clear_fail) sweep <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_hdr           = hdr;
  assign bus.o_hdr_valid     = hdr_valid;
  assign bus.o_gb_slip       = gb_slip;
  assign bus.o_slip_offset   = offset;
  assign bus.o_sync_fail     = sync_fail;
  assign bus.o_lock_loss_cnt = loss_cnt;
  assign bus.o_state         = state;
endmodule

// File: tb/tb_rx_slip_controller.sv
// Directed bench for rx_slip_controller: slips, holdoff, sweep failure and
// recovery, lock loss counting with saturation, and asynchronous reset.
module tb_rx_slip_controller;
  localparam int BLOCK_BITS   = 66;
  localparam int SLIP_HOLDOFF = 4;
  localparam int MAX_SWEEPS   = 2;
  localparam int LOSS_W       = 4;
  localparam int LOSS_MAX     = (1 << LOSS_W) - 1;

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_SLIP    = 3'd1;
  localparam logic [2:0] S_HOLDOFF = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   exp_off   = 0;
  int   exp_sweep = 0;
  int   exp_loss  = 0;

  rx_slip_controller_if #(.HDR_WIDTH(2), .BLOCK_BITS(BLOCK_BITS), .LOSS_CNT_WIDTH(LOSS_W)) bus ();

  rx_slip_controller #(
    .HDR_WIDTH(2), .BLOCK_BITS(BLOCK_BITS), .SLIP_HOLDOFF(SLIP_HOLDOFF),
    .MAX_SWEEPS(MAX_SWEEPS), .LOSS_CNT_WIDTH(LOSS_W)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, check header passthrough, advance header.
  task automatic step();
    logic [1:0] exp_hdr;
    exp_hdr = bus.i_hdr;
    @(posedge clk);
    #1;
    chk("hdr_data", bus.o_hdr, exp_hdr);
    bus.i_hdr = bus.i_hdr + 2'd1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_state"},  bus.o_state, S_HUNT);
    chk({tag, "_hdr"},    bus.o_hdr, 0);
    chk({tag, "_hvalid"}, bus.o_hdr_valid, 0);
    chk({tag, "_slip"},   bus.o_gb_slip, 0);
    chk({tag, "_offset"}, bus.o_slip_offset, 0);
    chk({tag, "_fail"},   bus.o_sync_fail, 0);
    chk({tag, "_loss"},   bus.o_lock_loss_cnt, 0);
  endtask

  // Issue one slip from HUNT or LOCKED and walk through the holdoff window.
  task automatic slip_once(input bit from_locked, input bit with_lock,
                           input bit toggle_req, input int gaps);
    bus.i_slip_req = 1'b1;
    if (with_lock) bus.i_block_lock = 1'b1;
    step();
    bus.i_slip_req   = 1'b0;
    bus.i_block_lock = 1'b0;
    chk("slip_state", bus.o_state, S_SLIP);
    chk("slip_pulse", bus.o_gb_slip, 1);
    if (from_locked) begin
      exp_sweep = 0;
      if (exp_loss < LOSS_MAX) exp_loss++;
      chk("loss_cnt", bus.o_lock_loss_cnt, exp_loss);
    end
    if (exp_off == BLOCK_BITS - 1) begin
      exp_off = 0;
      exp_sweep++;
    end else begin
      exp_off++;
    end
    step();
    chk("slip_offset", bus.o_slip_offset, exp_off);
    chk("pulse_width", bus.o_gb_slip, 0);
    if (exp_sweep == MAX_SWEEPS) begin
      chk("fail_state", bus.o_state, S_FAIL);
      chk("sync_fail_set", bus.o_sync_fail, 1);
      return;
    end
    chk("holdoff_state", bus.o_state, S_HOLDOFF);
    chk("no_fail", bus.o_sync_fail, 0);
    for (int h = 0; h < SLIP_HOLDOFF; h++) begin
      for (int g = 0; g < gaps; g++) begin
        bus.i_hdr_valid = 1'b0;
        if (toggle_req) bus.i_slip_req = ~bus.i_slip_req;
        step();
        chk("gap_state", bus.o_state, S_HOLDOFF);
        chk("gap_slip", bus.o_gb_slip, 0);
      end
      bus.i_hdr_valid = 1'b1;
      if (toggle_req) bus.i_slip_req = ~bus.i_slip_req;
      step();
      chk("hold_state", bus.o_state, (h == SLIP_HOLDOFF - 1) ? S_HUNT : S_HOLDOFF);
      chk("hold_blank", bus.o_hdr_valid, 0);
      chk("hold_slip", bus.o_gb_slip, 0);
    end
    bus.i_slip_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n            = 1'b1;
    bus.i_hdr        = 2'b00;
    bus.i_hdr_valid  = 1'b0;
    bus.i_slip_req   = 1'b0;
    bus.i_block_lock = 1'b0;
    bus.i_clear_fail = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk_zero_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Passthrough in HUNT, including a missing strobe and a stray clear.
    bus.i_hdr = 2'b01;
    bus.i_hdr_valid = 1'b1;
    step();
    chk("pass_valid", bus.o_hdr_valid, 1);
    chk("pass_state", bus.o_state, S_HUNT);
    bus.i_hdr_valid = 1'b0;
    step();
    chk("pass_novalid", bus.o_hdr_valid, 0);
    bus.i_hdr_valid  = 1'b1;
    bus.i_clear_fail = 1'b1;
    step();
    bus.i_clear_fail = 1'b0;
    chk("clear_ignored", bus.o_state, S_HUNT);
    chk("pass_valid2", bus.o_hdr_valid, 1);

    // First slip, then passthrough resumes with one cycle latency.
    slip_once(0, 0, 0, 0);
    step();
    chk("resume_valid", bus.o_hdr_valid, 1);
    chk("resume_state", bus.o_state, S_HUNT);

    // Finish the first sweep with mixed gaps, request toggling and lock priority.
    for (int i = 0; i < BLOCK_BITS - 1; i++)
      slip_once(0, (i == 10), (i % 7 == 3), (i % 5 == 2) ? 1 : 0);
    chk("sweep1_offset", bus.o_slip_offset, 0);
    chk("sweep1_nofail", bus.o_sync_fail, 0);

    // Second sweep ends in FAIL on the wrap.
    for (int i = 0; i < BLOCK_BITS; i++) slip_once(0, 0, 0, 0);
    bus.i_slip_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fail_noslip", bus.o_gb_slip, 0);
      chk("fail_hold", bus.o_state, S_FAIL);
      chk("fail_blank", bus.o_hdr_valid, 0);
      chk("fail_flag", bus.o_sync_fail, 1);
      chk("fail_offset", bus.o_slip_offset, 0);
    end
    bus.i_slip_req = 1'b0;

    bus.i_clear_fail = 1'b1;
    step();
    bus.i_clear_fail = 1'b0;
    exp_sweep = 0;
    chk("clear_state", bus.o_state, S_HUNT);
    chk("clear_flag", bus.o_sync_fail, 0);
    chk("clear_offset", bus.o_slip_offset, 0);
    step();
    chk("clear_pass", bus.o_hdr_valid, 1);
    slip_once(0, 0, 0, 0);

    // Reach sweep 1, then a lock loss must clear the sweep count.
    for (int i = 0; i < BLOCK_BITS - 1; i++) slip_once(0, 0, 0, 0);
    bus.i_block_lock = 1'b1;
    step();
    chk("lock_state", bus.o_state, S_LOCKED);
    step();
    chk("lock_pass", bus.o_hdr_valid, 1);
    slip_once(1, 0, 0, 0);
    for (int i = 0; i < BLOCK_BITS - 1; i++) slip_once(0, 0, 0, 0);
    chk("sweepclr_nofail", bus.o_sync_fail, 0);
    chk("sweepclr_state", bus.o_state, S_HUNT);

    // Lock dropping without a slip request returns to HUNT uncounted.
    bus.i_block_lock = 1'b1;
    step();
    chk("relock_state", bus.o_state, S_LOCKED);
    bus.i_block_lock = 1'b0;
    step();
    chk("drop_state", bus.o_state, S_HUNT);
    chk("drop_loss", bus.o_lock_loss_cnt, 1);
    chk("drop_noslip", bus.o_gb_slip, 0);

    // Repeated lock losses saturate the counter.
    for (int i = 0; i < LOSS_MAX + 1; i++) begin
      bus.i_block_lock = 1'b1;
      step();
      chk("sat_lock", bus.o_state, S_LOCKED);
      slip_once(1, 0, 0, 0);
    end
    chk("loss_saturated", bus.o_lock_loss_cnt, LOSS_MAX);

    // Asynchronous reset in the middle of HOLDOFF.
    bus.i_slip_req = 1'b1;
    step();
    bus.i_slip_req = 1'b0;
    step();
    step();
    chk("pre_reset_state", bus.o_state, S_HOLDOFF);
    #3 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    exp_off = 0;
    exp_sweep = 0;
    exp_loss = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_noslip", bus.o_gb_slip, 0);
      chk("post_reset_state", bus.o_state, S_HUNT);
      chk("post_reset_pass", bus.o_hdr_valid, 1);
    end
    slip_once(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
